// File: rtl/eth_measurer_pkg.sv
// Shared constants, record layout and event decode for the ethernet latency meter.
package eth_measurer_pkg;

    // Widest supported time field; narrower instances use the low bits.
    localparam int TIME_W_MAX = 48;
    // Time-field width of the record as seen by the default AXI/DMA readout.
    localparam int REC_TIME_W = 32;

    // All-ones marks "no result" in a time field.
    localparam logic [TIME_W_MAX-1:0] TIME_NONE = '1;

    // Readout record, same bit order as out_data.
    typedef struct packed {
        logic                  pong_ok;
        logic                  ping_ok;
        logic [REC_TIME_W-1:0] pong;
        logic [REC_TIME_W-1:0] ping;
    } latency_rec_t;

    // The single action taken in a cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_TX,
        EV_LOOP_END,
        EV_LOOP_TMO,
        EV_MAIN_END,
        EV_MAIN_TMO
    } meas_ev_e;

    // Priority: tx > loop_rx_end > loop_rx_timeout > main_rx_end > main_rx_timeout.
    function automatic meas_ev_e ev_select(input logic tx, input logic loop_end,
                                           input logic loop_tmo, input logic main_end,
                                           input logic main_tmo);
        if (tx)       return EV_TX;
        if (loop_end) return EV_LOOP_END;
        if (loop_tmo) return EV_LOOP_TMO;
        if (main_end) return EV_MAIN_END;
        if (main_tmo) return EV_MAIN_TMO;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/eth_latency_fifo.sv
// Synchronous first-word-fall-through record FIFO with optional drop-oldest on overflow.
module eth_latency_fifo #(
    parameter int WIDTH       = 66,
    parameter int DEPTH       = 16,
    parameter int DROP_OLDEST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam bit DROP_OLD = (DROP_OLDEST != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_d, wptr_q, rptr_d, rptr_q;
    logic [LW-1:0]    level_d, level_q;
    logic             ext_pop, int_pop, pop, wr_mem;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rptr_q];

    // Decide write/pop; on overflow either evict the head (drop-oldest) or refuse the write.
    always_comb begin
        ext_pop = rd_en & ~empty;
        int_pop = wr_en & full & ~ext_pop & DROP_OLD;
        wr_mem  = wr_en & (~full | ext_pop | DROP_OLD);
        pop     = ext_pop | int_pop;
        wptr_d  = wr_mem ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        if (wr_mem && !pop)      level_d = level_q + 1'b1;
        else if (!wr_mem && pop) level_d = level_q - 1'b1;
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage; contents are don't-care until written, reads of an empty FIFO return zero.
    always_ff @(posedge clk) begin
        if (wr_mem) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/eth_latency_meter.sv
// Round-trip latency meter: cycle timer, ping/pong capture, commit into a record FIFO.
module eth_latency_meter #(
    parameter int TIMER_W     = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DROP_OLDEST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          main_tx_begin,
    input  logic                          main_rx_end,
    input  logic                          main_rx_timeout,
    input  logic                          loop_tx_begin,
    input  logic                          loop_rx_end,
    input  logic                          loop_rx_timeout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*TIMER_W+1:0]          out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   drop_count
);

    import eth_measurer_pkg::*;

    localparam int REC_W = 2 * TIMER_W + 2;
    localparam logic [TIMER_W-1:0] T_NONE = TIME_NONE[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] T_MAX  = T_NONE - 1'b1;

    // Same field order as latency_rec_t, sized by this instance's timer width.
    typedef struct packed {
        logic               pong_ok;
        logic               ping_ok;
        logic [TIMER_W-1:0] pong;
        logic [TIMER_W-1:0] ping;
    } rec_t;

    localparam rec_t REC_RESET = '{pong_ok: 1'b0, ping_ok: 1'b0, pong: T_NONE, ping: T_NONE};

    meas_ev_e           ev_d, ev_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    rec_t               rec_d, rec_q;
    logic               push, drop;
    logic [31:0]        drop_count_d, drop_count_q;
    logic               fifo_full, fifo_empty;

    // Stage 1: resolve event priority and run the timer. The timer restarts at 2 so that the
    // capture, taken one stage later, reads cycles elapsed since tx plus the pipeline depth.
    always_comb begin
        ev_d = ev_select(main_tx_begin | loop_tx_begin, loop_rx_end, loop_rx_timeout,
                         main_rx_end, main_rx_timeout);
        if (ev_d == EV_TX)        timer_d = TIMER_W'(2);
        else if (timer_q == T_MAX) timer_d = timer_q;
        else                      timer_d = timer_q + 1'b1;
    end

    // Stage 2: apply the registered event to the capture record; commits push the updated record.
    always_comb begin
        rec_d = rec_q;
        push  = 1'b0;
        case (ev_q)
            EV_TX: rec_d = REC_RESET;
            EV_LOOP_END: begin
                rec_d.ping    = timer_q;
                rec_d.ping_ok = 1'b1;
            end
            EV_LOOP_TMO: begin
                rec_d = REC_RESET;
                push  = 1'b1;
            end
            EV_MAIN_END: begin
                rec_d.pong    = timer_q;
                rec_d.pong_ok = 1'b1;
                push          = 1'b1;
            end
            EV_MAIN_TMO: begin
                rec_d.pong    = T_NONE;
                rec_d.pong_ok = 1'b0;
                push          = 1'b1;
            end
            default: ;
        endcase
    end

    // A push into a full FIFO loses a record unless the consumer pops in the same cycle.
    always_comb begin
        drop         = push & fifo_full & ~(out_ready & ~fifo_empty);
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 32'hFFFF_FFFF) drop_count_d = drop_count_q + 32'd1;
    end

    // Timer, event pipeline, capture record and drop counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q         <= EV_NONE;
            timer_q      <= '0;
            rec_q        <= REC_RESET;
            drop_count_q <= '0;
        end else begin
            ev_q         <= ev_d;
            timer_q      <= timer_d;
            rec_q        <= rec_d;
            drop_count_q <= drop_count_d;
        end
    end

    eth_latency_fifo #(
        .WIDTH       (REC_W),
        .DEPTH       (FIFO_DEPTH),
        .DROP_OLDEST (DROP_OLDEST)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (rec_d),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid  = ~fifo_empty;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_eth_latency_meter.sv
// Bench for eth_latency_meter: two instances (32-bit/drop-oldest, 8-bit/drop-new) on shared
// stimulus, checked every cycle against a queue-based reference model plus directed cases.
module tb_eth_latency_meter;

    localparam int D = 16;
    localparam logic [5:0] E_MTX  = 6'h01;
    localparam logic [5:0] E_LTX  = 6'h02;
    localparam logic [5:0] E_LEND = 6'h04;
    localparam logic [5:0] E_LTMO = 6'h08;
    localparam logic [5:0] E_MEND = 6'h10;
    localparam logic [5:0] E_MTMO = 6'h20;
    localparam logic [47:0] NONE  = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic main_tx_begin = 1'b0, main_rx_end = 1'b0, main_rx_timeout = 1'b0;
    logic loop_tx_begin = 1'b0, loop_rx_end = 1'b0, loop_rx_timeout = 1'b0;
    logic out_ready = 1'b0;
    logic        va, vb;
    logic [65:0] da;
    logic [17:0] db;
    logic [4:0]  la, lb;
    logic [31:0] dca, dcb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    eth_latency_meter #(.TIMER_W(32), .FIFO_DEPTH(D), .DROP_OLDEST(1)) u_a (
        .clk(clk), .rst(rst),
        .main_tx_begin(main_tx_begin), .main_rx_end(main_rx_end), .main_rx_timeout(main_rx_timeout),
        .loop_tx_begin(loop_tx_begin), .loop_rx_end(loop_rx_end), .loop_rx_timeout(loop_rx_timeout),
        .out_valid(va), .out_ready(out_ready), .out_data(da), .fifo_level(la), .drop_count(dca));

    eth_latency_meter #(.TIMER_W(8), .FIFO_DEPTH(D), .DROP_OLDEST(0)) u_b (
        .clk(clk), .rst(rst),
        .main_tx_begin(main_tx_begin), .main_rx_end(main_rx_end), .main_rx_timeout(main_rx_timeout),
        .loop_tx_begin(loop_tx_begin), .loop_rx_end(loop_rx_end), .loop_rx_timeout(loop_rx_timeout),
        .out_valid(vb), .out_ready(out_ready), .out_data(db), .fifo_level(lb), .drop_count(dcb));

    // ---------------- reference model (index 0 = u_a, 1 = u_b) ----------------
    int              W[2]  = '{32, 8};
    bit              DO[2] = '{1'b1, 1'b0};
    longint unsigned cyc_n = 0;
    longint unsigned org[2];
    longint unsigned off[2];
    logic [47:0]     ping_v[2], pong_v[2];
    logic            ping_ok[2], pong_ok[2];
    logic            pend[2];
    logic [65:0]     pend_rec[2];
    longint unsigned drops[2];
    logic [65:0]     q0[$], q1[$];

    function automatic int qsize(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [65:0] qhead(int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(int m);
        if (m == 0) q0.delete(0); else q1.delete(0);
    endtask

    task automatic qpush(int m, logic [65:0] r);
        if (m == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // Time value captured for an event in the current cycle: cycles since the timer origin
    // plus its start offset, clamped below the all-ones marker.
    function automatic logic [47:0] tval(int m);
        longint unsigned d, mx;
        d  = cyc_n - org[m] + off[m];
        mx = (64'd1 << W[m]) - 64'd2;
        return (d > mx) ? mx[47:0] : d[47:0];
    endfunction

    function automatic logic [65:0] pack(int m);
        if (m == 0) return {pong_ok[0], ping_ok[0], pong_v[0][31:0], ping_v[0][31:0]};
        return {48'd0, pong_ok[1], ping_ok[1], pong_v[1][7:0], ping_v[1][7:0]};
    endfunction

    // Advance the model across one clock edge with the inputs held during that cycle.
    task automatic model_edge(input logic [5:0] ev, input logic rdy, input logic rs);
        for (int m = 0; m < 2; m++) begin
            if (rs) begin
                if (m == 0) q0.delete(); else q1.delete();
                pend[m] = 1'b0; drops[m] = 0;
                ping_v[m] = NONE; pong_v[m] = NONE; ping_ok[m] = 1'b0; pong_ok[m] = 1'b0;
                org[m] = cyc_n; off[m] = 0;
            end else begin
                // record committed last cycle meets the consumer this edge
                if (pend[m]) begin
                    if (qsize(m) == D && !(rdy && qsize(m) > 0)) begin
                        if (drops[m] != 64'hFFFF_FFFF) drops[m]++;
                        if (DO[m]) begin qpop(m); qpush(m, pend_rec[m]); end
                    end else begin
                        if (rdy && qsize(m) > 0) qpop(m);
                        qpush(m, pend_rec[m]);
                    end
                end else if (rdy && qsize(m) > 0) begin
                    qpop(m);
                end
                pend[m] = 1'b0;
                // this cycle's event, highest priority only
                if (ev[0] || ev[1]) begin
                    org[m] = cyc_n; off[m] = 2;
                    ping_v[m] = NONE; pong_v[m] = NONE; ping_ok[m] = 1'b0; pong_ok[m] = 1'b0;
                end else if (ev[2]) begin
                    ping_v[m] = tval(m); ping_ok[m] = 1'b1;
                end else if (ev[3]) begin
                    ping_v[m] = NONE; pong_v[m] = NONE; ping_ok[m] = 1'b0; pong_ok[m] = 1'b0;
                    pend[m] = 1'b1; pend_rec[m] = pack(m);
                end else if (ev[4]) begin
                    pong_v[m] = tval(m); pong_ok[m] = 1'b1;
                    pend[m] = 1'b1; pend_rec[m] = pack(m);
                end else if (ev[5]) begin
                    pong_v[m] = NONE; pong_ok[m] = 1'b0;
                    pend[m] = 1'b1; pend_rec[m] = pack(m);
                end
            end
        end
        cyc_n++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("a_valid", 128'(va), 128'(qsize(0) != 0));
        check("a_level", 128'(la), 128'(qsize(0)));
        check("a_drops", 128'(dca), 128'(drops[0]));
        if (qsize(0) != 0) check("a_data", 128'(da), 128'(qhead(0)));
        check("b_valid", 128'(vb), 128'(qsize(1) != 0));
        check("b_level", 128'(lb), 128'(qsize(1)));
        check("b_drops", 128'(dcb), 128'(drops[1]));
        if (qsize(1) != 0) check("b_data", 128'({48'd0, db}), 128'(qhead(1)));
    endtask

    // One clock: drive at negedge, update model at posedge, compare at the next negedge.
    task automatic step(input logic [5:0] ev, input logic rdy, input logic rs);
        {main_rx_timeout, main_rx_end, loop_rx_timeout, loop_rx_end, loop_tx_begin, main_tx_begin} = ev;
        out_ready = rdy;
        rst       = rs;
        @(posedge clk);
        model_edge(ev, rdy, rs);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(6'd0, rdy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] ev;
        logic       rdy;
        int         r;

        @(negedge clk);
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b1);
        check("rst_valid", 128'(va), 128'(0));
        check("rst_data",  128'(da), 128'(0));
        check("rst_level", 128'(la), 128'(0));
        check("rst_drops", 128'(dca), 128'(0));

        // ping 10 cycles and pong 25 cycles after tx
        step(E_MTX, 1'b0, 1'b0);
        idle(9, 1'b0);
        step(E_LEND, 1'b0, 1'b0);
        idle(14, 1'b0);
        step(E_MEND, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("pingpong_a", 128'(da), 128'({1'b1, 1'b1, 32'd27, 32'd12}));
        check("pingpong_b", 128'(db), 128'({1'b1, 1'b1, 8'd27, 8'd12}));
        step(6'd0, 1'b1, 1'b0);

        // loop timeout commits an all-ones record, visible two cycles after the event
        step(E_LTX, 1'b0, 1'b0);
        step(E_LTMO, 1'b0, 1'b0);
        check("tmo_early_valid", 128'(va), 128'(0));
        step(6'd0, 1'b0, 1'b0);
        check("tmo_valid", 128'(va), 128'(1));
        check("tmo_data_a", 128'(da), 128'({2'b00, 64'hFFFF_FFFF_FFFF_FFFF}));
        check("tmo_data_b", 128'(db), 128'({2'b00, 16'hFFFF}));
        step(6'd0, 1'b1, 1'b0);

        // tx wins over main_rx_end in the same cycle: no commit, timer restarts at 2
        step(E_MTX | E_MEND, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("txmain_level_a", 128'(la), 128'(0));
        check("txmain_level_b", 128'(lb), 128'(0));
        step(E_MEND, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("txmain_pong", 128'(da), 128'({1'b1, 1'b0, 32'd7, 32'hFFFF_FFFF}));
        step(6'd0, 1'b1, 1'b0);

        // long silence saturates the 8-bit timer
        step(E_MTX, 1'b0, 1'b0);
        idle(300, 1'b0);
        step(E_MEND, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("sat_b", 128'(db), 128'({1'b1, 1'b0, 8'hFE, 8'hFF}));
        check("sat_a", 128'(da), 128'({1'b1, 1'b0, 32'd303, 32'hFFFF_FFFF}));
        step(6'd0, 1'b1, 1'b0);

        // 18 commits into a stalled FIFO: record n carries pong 2n-1
        step(6'd0, 1'b0, 1'b1);
        for (int k = 0; k < 18; k++) begin
            step(E_MEND, 1'b0, 1'b0);
            step(6'd0, 1'b0, 1'b0);
        end
        check("ovf_level_a", 128'(la), 128'(16));
        check("ovf_level_b", 128'(lb), 128'(16));
        check("ovf_drops_a", 128'(dca), 128'(2));
        check("ovf_drops_b", 128'(dcb), 128'(2));
        check("ovf_first_a", 128'(da), 128'({1'b1, 1'b0, 32'd5, 32'hFFFF_FFFF}));
        check("ovf_first_b", 128'(db), 128'({1'b1, 1'b0, 8'd1, 8'hFF}));
        idle(15, 1'b1);
        check("ovf_last_a", 128'(da), 128'({1'b1, 1'b0, 32'd35, 32'hFFFF_FFFF}));
        check("ovf_last_b", 128'(db), 128'({1'b1, 1'b0, 8'd31, 8'hFF}));

        // reset with records queued
        for (int k = 0; k < 4; k++) begin
            step(E_MEND, 1'b0, 1'b0);
            step(6'd0, 1'b0, 1'b0);
        end
        check("q5_level", 128'(la), 128'(5));
        step(6'd0, 1'b0, 1'b1);
        check("rstq_level_a", 128'(la), 128'(0));
        check("rstq_valid_a", 128'(va), 128'(0));
        check("rstq_drops_a", 128'(dca), 128'(0));
        check("rstq_level_b", 128'(lb), 128'(0));
        check("rstq_drops_b", 128'(dcb), 128'(0));

        // full FIFO with push and pop in the same cycle
        for (int k = 0; k < 16; k++) begin
            step(E_MEND, 1'b0, 1'b0);
            step(6'd0, 1'b0, 1'b0);
        end
        step(E_MEND, 1'b0, 1'b0);
        step(6'd0, 1'b1, 1'b0);
        check("fullpp_level_a", 128'(la), 128'(16));
        check("fullpp_drops_a", 128'(dca), 128'(0));
        check("fullpp_level_b", 128'(lb), 128'(16));
        check("fullpp_drops_b", 128'(dcb), 128'(0));
        check("fullpp_head_a", 128'(da), 128'({1'b1, 1'b0, 32'd3, 32'hFFFF_FFFF}));
        idle(20, 1'b1);

        // randomized traffic: mixed/simultaneous events, varying backpressure, rare resets
        for (int i = 0; i < 2500; i++) begin
            if (i % 500 == 250) idle(280, 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (r < 3)       ev = 6'd1 << $urandom_range(0, 5);
            else if (r == 3) ev = 6'($urandom);
            else             ev = 6'd0;
            if ((i / 500) % 2 == 1) rdy = ($urandom_range(0, 3) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            step(ev, rdy, 1'($urandom_range(0, 599) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
